fixed_requant: RTL and testbench



---
 rtl/fixed_requant_pkg.sv | 16 +
 rtl/requant_unit.sv | 96 +++++++++
 rtl/fixed_requant.sv | 104 ++++++++++
 tb/tb_fixed_requant.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_requant_pkg.sv
// Shared definitions for the requantizer and the layer/network modules that chain it.
// Holds the output-mode encodings and a ceil(log2) helper for sizing counters.
package fixed_requant_pkg;

  localparam int MODE_SIGNED = 0;
  localparam int MODE_RELU   = 1;
  localparam int MODE_UINT   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'(1) << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/requant_unit.sv
// One channel of the requantizer: fraction alignment with round-half-up (stage 1),
// then mode-dependent clipping (stage 2). sat flags the element clipped in stage 2 now.
module requant_unit
  import fixed_requant_pkg::*;
#(
  parameter int IN_INT_BITW   = 5,
  parameter int IN_FRAC_BITW  = 8,
  parameter int OUT_INT_BITW  = 5,
  parameter int OUT_FRAC_BITW = 8,
  parameter int MODE          = 0
) (
  input  logic                                   clock,
  input  logic                                   n_rst,
  input  logic [IN_INT_BITW+IN_FRAC_BITW-1:0]    sample,
  output logic [OUT_INT_BITW+OUT_FRAC_BITW-1:0]  result,
  output logic                                   sat
);

  localparam int IN_BITW  = IN_INT_BITW + IN_FRAC_BITW;
  localparam int OUT_BITW = OUT_INT_BITW + OUT_FRAC_BITW;
  localparam int S        = IN_FRAC_BITW - OUT_FRAC_BITW;
  localparam int ABS_S    = (S < 0) ? -S : S;
  localparam int AW       = IN_BITW + ABS_S + 1;
  // Compare width must hold the unsigned bound 2^OUT_BITW-1 as a positive number.
  localparam int CW       = (AW > OUT_BITW + 1) ? AW : OUT_BITW + 2;

  localparam logic signed [CW-1:0] SMAX = (CW'(1) <<< (OUT_BITW - 1)) - CW'(1);
  localparam logic signed [CW-1:0] SMIN = -(CW'(1) <<< (OUT_BITW - 1));
  localparam logic signed [CW-1:0] UMAX = (CW'(1) <<< OUT_BITW) - CW'(1);
  localparam logic [OUT_BITW-1:0]  SMAX_O = SMAX[OUT_BITW-1:0];
  localparam logic [OUT_BITW-1:0]  SMIN_O = SMIN[OUT_BITW-1:0];
  localparam logic [OUT_BITW-1:0]  UMAX_O = UMAX[OUT_BITW-1:0];

  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] aligned;
  logic signed [AW-1:0] stage1;
  logic signed [CW-1:0] wide;
  logic [OUT_BITW-1:0]  clipped;

  assign ext = AW'(signed'(sample));

  if (S > 0) begin : g_round
    localparam logic signed [AW-1:0] HALF = AW'(1) <<< (S - 1);
    assign aligned = (ext + HALF) >>> S;
  end else if (S < 0) begin : g_widen
    assign aligned = ext <<< ABS_S;
  end else begin : g_pass
    assign aligned = ext;
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) stage1 <= '0;
    else        stage1 <= aligned;
  end

  assign wide = CW'(stage1);

  // Zeroing negatives in ReLU/unsigned modes is not a saturation event.
  always_comb begin
    clipped = wide[OUT_BITW-1:0];
    sat     = 1'b0;
    case (MODE)
      MODE_SIGNED: begin
        if (wide > SMAX) begin
          clipped = SMAX_O;
          sat     = 1'b1;
        end else if (wide < SMIN) begin
          clipped = SMIN_O;
          sat     = 1'b1;
        end
      end
      MODE_RELU: begin
        if (wide[CW-1]) begin
          clipped = '0;
        end else if (wide > SMAX) begin
          clipped = SMAX_O;
          sat     = 1'b1;
        end
      end
      default: begin
        if (wide[CW-1]) begin
          clipped = '0;
        end else if (wide > UMAX) begin
          clipped = UMAX_O;
          sat     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) result <= '0;
    else        result <= clipped;
  end

endmodule

// File: rtl/fixed_requant.sv
// Multi-channel fixed-point requantizer with 2-cycle latency, coordinate pass-through
// and a per-frame saturation count. Streaming: every cycle carries a pixel, no handshake.
module fixed_requant
  import fixed_requant_pkg::*;
#(
  parameter int W_HEIGHT      = -1,
  parameter int W_WIDTH       = -1,
  parameter int UNITS         = 12,
  parameter int IN_INT_BITW   = 5,
  parameter int IN_FRAC_BITW  = 8,
  parameter int OUT_INT_BITW  = 5,
  parameter int OUT_FRAC_BITW = 8,
  parameter int MODE          = 0,
  parameter int CNT_BITW      = 16,
  localparam int V_BITW   = (clog2(W_HEIGHT) < 1) ? 1 : clog2(W_HEIGHT),
  localparam int H_BITW   = (clog2(W_WIDTH) < 1) ? 1 : clog2(W_WIDTH),
  localparam int IN_BITW  = IN_INT_BITW + IN_FRAC_BITW,
  localparam int OUT_BITW = OUT_INT_BITW + OUT_FRAC_BITW
) (
  input  logic                        clock,
  input  logic                        n_rst,
  input  logic [IN_BITW*UNITS-1:0]    in_data,
  input  logic [V_BITW-1:0]           in_vcnt,
  input  logic [H_BITW-1:0]           in_hcnt,
  output logic [OUT_BITW*UNITS-1:0]   out_data,
  output logic [V_BITW-1:0]           out_vcnt,
  output logic [H_BITW-1:0]           out_hcnt,
  output logic [CNT_BITW-1:0]         sat_count,
  output logic                        sat_valid
);

  localparam int PW = clog2(UNITS + 1);
  localparam int SW = ((CNT_BITW > PW) ? CNT_BITW : PW) + 1;
  localparam logic [CNT_BITW-1:0] CNT_MAX = '1;

  if (OUT_BITW < 2 || MODE < MODE_SIGNED || MODE > MODE_UINT) begin : g_bad_cfg
    $error("fixed_requant: OUT_BITW must be >= 2 and MODE in 0..2");
  end

  logic [UNITS-1:0]    sat_flags;
  logic [PW-1:0]       pop;
  logic [V_BITW-1:0]   vcnt_d1;
  logic [H_BITW-1:0]   hcnt_d1;
  logic [CNT_BITW-1:0] acc;
  logic [CNT_BITW-1:0] base;
  logic [CNT_BITW-1:0] total;
  logic [SW-1:0]       sum;
  logic                frame_start;
  logic                frame_end;

  for (genvar k = 0; k < UNITS; k++) begin : g_unit
    requant_unit #(
      .IN_INT_BITW  (IN_INT_BITW),
      .IN_FRAC_BITW (IN_FRAC_BITW),
      .OUT_INT_BITW (OUT_INT_BITW),
      .OUT_FRAC_BITW(OUT_FRAC_BITW),
      .MODE         (MODE)
    ) u_unit (
      .clock (clock),
      .n_rst (n_rst),
      .sample(in_data[k*IN_BITW +: IN_BITW]),
      .result(out_data[k*OUT_BITW +: OUT_BITW]),
      .sat   (sat_flags[k])
    );
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < UNITS; k++) pop = pop + PW'(sat_flags[k]);
  end

  // vcnt_d1/hcnt_d1 travel alongside the data currently being clipped.
  assign frame_start = (vcnt_d1 == '0) && (hcnt_d1 == '0);
  assign frame_end   = (vcnt_d1 == V_BITW'(W_HEIGHT - 1)) && (hcnt_d1 == H_BITW'(W_WIDTH - 1));
  // A (0,0) pixel always opens a fresh frame, discarding any truncated frame's tally.
  assign base  = frame_start ? '0 : acc;
  assign sum   = SW'(base) + SW'(pop);
  assign total = (sum > SW'(CNT_MAX)) ? CNT_MAX : sum[CNT_BITW-1:0];

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      vcnt_d1   <= '0;
      hcnt_d1   <= '0;
      out_vcnt  <= '0;
      out_hcnt  <= '0;
      acc       <= '0;
      sat_count <= '0;
      sat_valid <= 1'b0;
    end else begin
      vcnt_d1   <= in_vcnt;
      hcnt_d1   <= in_hcnt;
      out_vcnt  <= vcnt_d1;
      out_hcnt  <= hcnt_d1;
      sat_valid <= frame_end;
      if (frame_end) begin
        sat_count <= total;
        acc       <= '0;
      end else begin
        acc <= total;
      end
    end
  end

endmodule

// File: tb/tb_fixed_requant.sv
// Bench for fixed_requant: four configurations share one input stream; a reference model
// pushes expected pixels into a queue and a monitor compares them as they emerge.
module tb_fixed_requant;

  localparam int WH      = 4;
  localparam int WW      = 4;
  localparam int UNITS   = 12;
  localparam int IN_BITW = 13;
  localparam int NDUT    = 4;
  localparam int DW      = 144;
  localparam int VB      = 2;
  localparam int HB      = 2;
  localparam int OUT_INT  [NDUT] = '{3, 3, 8, 2};
  localparam int OUT_FRAC [NDUT] = '{8, 8, 0, 10};
  localparam int MODE_SEL [NDUT] = '{0, 1, 2, 2};
  localparam int CNT_W    [NDUT] = '{16, 4, 16, 16};

  typedef struct packed {
    logic [NDUT-1:0][DW-1:0] data;
    logic [NDUT-1:0][15:0]   cnt;
    logic                    fe;
    logic [VB-1:0]           v;
    logic [HB-1:0]           h;
  } exp_t;

  // ---------------- clock / reset / DUTs ----------------
  logic                     clock = 1'b0;
  logic                     n_rst;
  logic [IN_BITW*UNITS-1:0] in_data;
  logic [VB-1:0]            in_vcnt;
  logic [HB-1:0]            in_hcnt;
  logic [DW-1:0]            act_data  [NDUT];
  logic [VB-1:0]            act_v     [NDUT];
  logic [HB-1:0]            act_h     [NDUT];
  logic [15:0]              act_cnt   [NDUT];
  logic                     act_valid [NDUT];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int OB = OUT_INT[g] + OUT_FRAC[g];
    logic [OB*UNITS-1:0]  od;
    logic [CNT_W[g]-1:0]  cnt;
    fixed_requant #(
      .W_HEIGHT(WH), .W_WIDTH(WW), .UNITS(UNITS),
      .IN_INT_BITW(5), .IN_FRAC_BITW(8),
      .OUT_INT_BITW(OUT_INT[g]), .OUT_FRAC_BITW(OUT_FRAC[g]),
      .MODE(MODE_SEL[g]), .CNT_BITW(CNT_W[g])
    ) u_dut (
      .clock    (clock),
      .n_rst    (n_rst),
      .in_data  (in_data),
      .in_vcnt  (in_vcnt),
      .in_hcnt  (in_hcnt),
      .out_data (od),
      .out_vcnt (act_v[g]),
      .out_hcnt (act_h[g]),
      .sat_count(cnt),
      .sat_valid(act_valid[g])
    );
    assign act_data[g] = DW'(od);
    assign act_cnt[g]  = 16'(cnt);
  end

  // ---------------- scoreboard state ----------------
  exp_t               exp_q[$];
  int                 n_checks = 0;
  int                 n_pass   = 0;
  logic [IN_BITW-1:0] px [UNITS];
  int                 acc  [NDUT];
  int                 held [NDUT];
  logic               drive_active = 1'b0;
  logic               vld_d1, vld_d2;

  task automatic check(input string name, input int g, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h", name, g, act, exp);
  endtask

  // Reference: scale by 2^(out_frac-in_frac), round half toward +inf, then clip by mode.
  function automatic logic [11:0] requant_ref(input int x, input int g, output bit sat);
    real    f, scaled;
    longint q, smax, smin, umax;
    int     ob;
    ob = OUT_INT[g] + OUT_FRAC[g];
    f  = 1.0;
    for (int i = 0; i < OUT_FRAC[g] - 8; i++) f = f * 2.0;
    for (int i = 0; i < 8 - OUT_FRAC[g]; i++) f = f / 2.0;
    scaled = $floor(real'(x) * f + 0.5);
    q    = longint'(scaled);
    smax = (longint'(1) << (ob - 1)) - 1;
    smin = -(longint'(1) << (ob - 1));
    umax = (longint'(1) << ob) - 1;
    sat  = 1'b0;
    if (MODE_SEL[g] == 0) begin
      if (q > smax) begin q = smax; sat = 1'b1; end
      else if (q < smin) begin q = smin; sat = 1'b1; end
    end else begin
      if (q < 0) q = 0;
      else if (q > ((MODE_SEL[g] == 1) ? smax : umax)) begin
        q = (MODE_SEL[g] == 1) ? smax : umax;
        sat = 1'b1;
      end
    end
    return 12'(q & umax);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_pixel(input int v, input int h);
    exp_t        e;
    bit          s;
    int          pop, ob, lim;
    logic [11:0] val;
    @(posedge clock);
    #1;
    for (int k = 0; k < UNITS; k++) in_data[k*IN_BITW +: IN_BITW] = px[k];
    in_vcnt      = VB'(v);
    in_hcnt      = HB'(h);
    drive_active = 1'b1;
    e    = '0;
    e.v  = VB'(v);
    e.h  = HB'(h);
    e.fe = (v == WH - 1) && (h == WW - 1);
    for (int g = 0; g < NDUT; g++) begin
      ob  = OUT_INT[g] + OUT_FRAC[g];
      pop = 0;
      for (int k = 0; k < UNITS; k++) begin
        val = requant_ref(int'($signed(px[k])), g, s);
        e.data[g] = e.data[g] | (DW'(val) << (k * ob));
        pop += int'(s);
      end
      lim = (1 << CNT_W[g]) - 1;
      if (v == 0 && h == 0) acc[g] = 0;
      acc[g] = (acc[g] + pop > lim) ? lim : acc[g] + pop;
      if (e.fe) begin
        held[g] = acc[g];
        acc[g]  = 0;
      end
      e.cnt[g] = 16'(held[g]);
    end
    exp_q.push_back(e);
  endtask

  task automatic fill_px(input int kind, input int v, input int h);
    for (int k = 0; k < UNITS; k++) px[k] = '0;
    case (kind)
      1: begin
        if (v == 0 && h == 0) begin
          px[0] = 13'h0080; px[1] = 13'h0140; px[2] = 13'h1F80;
          px[3] = 13'h0500; px[4] = 13'h0500;
        end else if (v == 0 && h == 1) px[5] = 13'h0500;
        else if (v == 0 && h == 2) for (int k = 0; k < UNITS; k++) px[k] = 13'h1F00;
        else if (v == 0 && h == 3) for (int k = 0; k < UNITS; k++) px[k] = 13'h0100;
        else if (v == 3 && h == 0) px[0] = 13'h1B00;
        else if (v == 3 && h == 2) px[7] = 13'h0500;
      end
      2: begin
        if (v == 1 && h == 1) for (int k = 0; k < UNITS; k++) px[k] = 13'h0500;
        else if (v == 1 && h == 2) for (int k = 0; k < UNITS; k++) px[k] = 13'h1B00;
      end
      4: if (v == 0) for (int k = 0; k < UNITS; k++) px[k] = 13'h0500;
      5: for (int k = 0; k < UNITS; k++)
           px[k] = ($urandom_range(1, 0) == 1) ? 13'($urandom)
                                               : 13'($urandom_range(2047, 0) - 1024);
      6: begin
        if (v == 1 && h == 0) px[0] = 13'h0500;
        else if (v == 2 && h == 2) px[1] = 13'h0500;
      end
      default: ;
    endcase
  endtask

  task automatic drive_frame(input int kind, input int rows);
    for (int v = 0; v < rows; v++)
      for (int h = 0; h < WW; h++) begin
        fill_px(kind, v, h);
        drive_pixel(v, h);
      end
  endtask

  task automatic check_reset_outputs();
    for (int g = 0; g < NDUT; g++) begin
      check("reset_data",  g, act_data[g], '0);
      check("reset_coord", g, DW'({act_v[g], act_h[g]}), '0);
      check("reset_count", g, DW'(act_cnt[g]), '0);
      check("reset_valid", g, DW'(act_valid[g]), '0);
    end
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #2;
    n_rst        = 1'b0;
    drive_active = 1'b0;
    in_data      = '0;
    in_vcnt      = '0;
    in_hcnt      = '0;
    exp_q.delete();
    for (int g = 0; g < NDUT; g++) begin
      acc[g]  = 0;
      held[g] = 0;
    end
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_rst = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      vld_d1 <= 1'b0;
      vld_d2 <= 1'b0;
    end else begin
      vld_d1 <= drive_active;
      vld_d2 <= vld_d1;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (vld_d2) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL queue_underflow: got output with 0 expected entries");
      end else begin
        e = exp_q.pop_front();
        for (int g = 0; g < NDUT; g++) begin
          check("data",      g, act_data[g], e.data[g]);
          check("coord",     g, DW'({act_v[g], act_h[g]}), DW'({e.v, e.h}));
          check("sat_valid", g, DW'(act_valid[g]), DW'(e.fe));
          check("sat_count", g, DW'(act_cnt[g]), DW'(e.cnt[g]));
        end
      end
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    n_rst   = 1'b1;
    in_data = '0;
    in_vcnt = '0;
    in_hcnt = '0;
    for (int k = 0; k < UNITS; k++) px[k] = '0;
    for (int g = 0; g < NDUT; g++) begin
      acc[g]  = 0;
      held[g] = 0;
    end
    #1 n_rst = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_rst = 1'b1;

    drive_frame(1, WH);   // rounding cases, ReLU zeroing, 5 saturations in modes 0
    drive_frame(2, WH);   // all channels saturate high then low
    drive_frame(3, WH);   // clean frame reports 0
    drive_frame(4, WH);   // 48 saturations: 4-bit counter sticks at 15
    drive_frame(4, WH);
    repeat (6) drive_frame(5, WH);
    drive_frame(5, 2);    // truncated frame, restarted at (0,0)
    drive_frame(5, WH);
    drive_frame(5, 2);    // reset lands mid-frame
    apply_reset();
    drive_frame(6, WH);   // fresh frame with exactly 2 saturating elements
    repeat (2) drive_frame(5, WH);

    @(posedge clock);
    #1;
    drive_active = 1'b0;
    in_data      = '0;
    in_vcnt      = '0;
    in_hcnt      = '0;
    repeat (4) @(posedge clock);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
